keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side counterpart of the multiplexed seven-segment digit driver. The display block time-multiplexes outputs by walking one active-low strobe across the digits. This block walks one active-low strobe across the columns of a 4x4 matrix keypad and reads the row lines back. It debounces the full 16-key snapshot and reports single key presses as a 4-bit code with a one-cycle valid pulse, which the board top feeds into the BCD digit registers.

## Interface
- SCAN_DIV, default 131072: clock cycles each column stays strobed; must be at least 2.
- DEBOUNCE_SCANS, default 4: consecutive identical full scans required before the debounced state updates; range 1..255.
- Clk  input  1  system clock, 100 MHz on board.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Rows  input  4  row sense lines, active low (externally pulled up); Rows[r]=0 means a key in row r of the strobed column is pressed.
- Cols  output  4  column strobes, active low, exactly one low at a time.
- KeyCode  output  4  last accepted key, code = 4*r + c.
- KeyValid  output  1  one-cycle pulse when a new key is accepted.
- KeyHeld  output  1  high while the accepted key remains the only debounced key down.

## Operation
- The divider counts 0..SCAN_DIV-1 and wraps. On wrap, Cols rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Cols=1110 strobes column 0.
- Rows are sampled only on the cycle where the divider equals SCAN_DIV-1, which gives the lines the full column period to settle. The sample is inverted into active-high bits snap[4*r+c] for the current column c.
- Scan end is the sample cycle of column 3. On that cycle:
  - If the completed snapshot equals the previous snapshot, runlen increments, saturating at DEBOUNCE_SCANS. Otherwise runlen becomes 1.
  - The snapshot is copied to prev.
  - When runlen reaches DEBOUNCE_SCANS, deb takes the value of the snapshot.
- Classification of deb: NONE if all bits are 0; ONE(k) if exactly bit k is set; MULTI otherwise.
- FSM states are IDLE, PRESSED and LOCKOUT. It is evaluated on the cycle after each scan end.
  - IDLE, ONE(k): KeyCode<=k, KeyValid pulse, go to PRESSED.
  - IDLE, MULTI: go to LOCKOUT.
  - IDLE, NONE: stay.
  - PRESSED, NONE: go to IDLE.
  - PRESSED, same ONE(k): stay.
  - PRESSED, MULTI or a different ONE: go to LOCKOUT. No rollover; KeyCode is unchanged.
  - LOCKOUT, NONE: go to IDLE.
  - LOCKOUT, anything else: stay. KeyValid never fires from LOCKOUT.
- KeyHeld = (state == PRESSED).
- KeyCode holds its value until the next accepted key.

## Timing
- Reset values: Cols=1110, KeyCode=0, KeyValid=0, KeyHeld=0, divider=0, snap=prev=deb=0, runlen=0, state=IDLE. All take effect asynchronously, including mid-scan and mid-press.
- The first column period after reset deassertion is a full SCAN_DIV cycles.
- One full scan is 4*SCAN_DIV cycles.
- KeyValid rises exactly one cycle after the scan-end cycle in which deb first becomes ONE(k).
- KeyHeld and KeyCode update on that same cycle.
- Press-to-KeyValid latency, for a key stable at the pins: at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 1 cycles, at least (DEBOUNCE_SCANS-1)*4*SCAN_DIV + 1 cycles.
- Release: KeyHeld falls one cycle after the scan end at which deb becomes NONE. There is no pulse on release.
- Any row change between sample instants is invisible. Bounce is filtered only through snapshot mismatch.
- runlen saturates and never wraps, so a key held indefinitely produces exactly one KeyValid.

## Test plan
- Reset behaviour (SCAN_DIV=4, DEBOUNCE_SCANS=3):
  - Assert Reset asynchronously mid-column -> Cols=1110 and all outputs 0 within the same cycle.
  - After release, Cols steps every 4 cycles, wrapping after 16.
- Single press: drive Rows[2]=0 only while Cols[1]=0, held for 6 scans -> exactly one KeyValid pulse, KeyCode=9, KeyHeld=1. Releasing drops KeyHeld after at most 4 scans with no further pulse.
- Bounce: toggle the key-9 row line every 5 cycles for 2 scans, then hold steady -> exactly one KeyValid, no earlier than 2 scans after bouncing stops.
- Short press: key 5 held for exactly 2 aligned scans (fewer than DEBOUNCE_SCANS) -> no KeyValid; KeyCode keeps its prior value.
- Multi-key lockout:
  - Press keys 0 and 15 together -> no KeyValid, KeyHeld=0.
  - Release key 15 only -> still no KeyValid.
  - Release all, then press key 3 -> KeyValid with KeyCode=3.
- Reset while PRESSED with key 6 still held -> KeyHeld=0 and KeyCode=0 immediately; after reset release, a new KeyValid with KeyCode=6 within the latency bound.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces full
// 16-key snapshots and reports single accepted presses with a one-cycle pulse.
module keypad_scanner #(
   parameter int SCAN_DIV       = 131072,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Rows,
   output logic [3:0] Cols,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic       KeyHeld
);

   localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [7:0]        RUN_MAX  = 8'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;

   logic [DIV_W-1:0] div_reg;
   logic [3:0]       cols_reg;
   logic [1:0]       col_idx_reg;
   logic [15:0]      snap_reg;
   logic [15:0]      prev_reg;
   logic [15:0]      deb_reg;
   logic [7:0]       runlen_reg;
   logic             scan_end_d_reg;
   state_t           state_reg;
   logic [3:0]       key_code_reg;
   logic             key_valid_reg;

   logic             sample;
   logic             scan_end;
   logic [15:0]      snap_next;
   logic [7:0]       runlen_next;
   logic             deb_none;
   logic             deb_one;
   logic [3:0]       deb_idx;

   assign sample   = (div_reg == DIV_LAST);
   assign scan_end = sample && (col_idx_reg == 2'd3);

   // On the sample cycle the strobed column's bits are replaced with the
   // inverted rows, so at scan end snap_next is the completed snapshot.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_snap
         assign snap_next[gi] = (sample && (col_idx_reg == 2'(gi % 4))) ?
                                ~Rows[gi / 4] : snap_reg[gi];
      end
   endgenerate

   always_comb begin
      runlen_next = 8'd1;
      if (snap_next == prev_reg)
         runlen_next = (runlen_reg >= RUN_MAX) ? RUN_MAX : runlen_reg + 8'd1;
   end

   always_comb begin
      deb_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (deb_reg[i]) deb_idx = 4'(i);
   end

   assign deb_none = (deb_reg == 16'd0);
   assign deb_one  = !deb_none && ((deb_reg & (deb_reg - 16'd1)) == 16'd0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_reg        <= '0;
         cols_reg       <= 4'b1110;
         col_idx_reg    <= 2'd0;
         snap_reg       <= '0;
         prev_reg       <= '0;
         deb_reg        <= '0;
         runlen_reg     <= '0;
         scan_end_d_reg <= 1'b0;
      end else begin
         scan_end_d_reg <= scan_end;
         snap_reg       <= snap_next;
         if (sample) begin
            div_reg     <= '0;
            cols_reg    <= {cols_reg[2:0], cols_reg[3]};
            col_idx_reg <= col_idx_reg + 2'd1;
         end else begin
            div_reg     <= div_reg + DIV_W'(1);
         end
         if (scan_end) begin
            prev_reg   <= snap_next;
            runlen_reg <= runlen_next;
            if (runlen_next == RUN_MAX)
               deb_reg <= snap_next;
         end
      end
   end

   // Key FSM runs once per scan, the cycle after deb may have changed.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= IDLE;
         key_code_reg  <= 4'd0;
         key_valid_reg <= 1'b0;
      end else begin
         key_valid_reg <= 1'b0;
         if (scan_end_d_reg) begin
            case (state_reg)
               IDLE: begin
                  if (deb_one) begin
                     key_code_reg  <= deb_idx;
                     key_valid_reg <= 1'b1;
                     state_reg     <= PRESSED;
                  end else if (!deb_none) begin
                     state_reg <= LOCKOUT;
                  end
               end
               PRESSED: begin
                  if (deb_none)
                     state_reg <= IDLE;
                  else if (!(deb_one && (deb_idx == key_code_reg)))
                     state_reg <= LOCKOUT;
               end
               LOCKOUT: begin
                  if (deb_none) state_reg <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign Cols     = cols_reg;
   assign KeyCode  = key_code_reg;
   assign KeyValid = key_valid_reg;
   assign KeyHeld  = (state_reg == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected key codes are queued with the
// stimulus and a monitor pops one per KeyValid pulse.
module tb_keypad_scanner;

   localparam int SD   = 4;
   localparam int DEB  = 3;
   localparam int SCAN = 4 * SD;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [3:0] Rows;
   logic [3:0] Cols;
   logic [3:0] KeyCode;
   logic       KeyValid;
   logic       KeyHeld;

   logic [15:0] keys = 16'd0;
   int          checks = 0;
   int          errors = 0;
   int          cycle_cnt = 0;
   int          last_valid_cycle = 0;
   int          mark;
   logic [3:0]  exp_q[$];

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
      .Clk(Clk), .Reset(Reset), .Rows(Rows), .Cols(Cols),
      .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

   // Passive keypad matrix: a pressed key pulls its row low while its column is strobed.
   always_comb begin
      Rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!Cols[c] && keys[4*r + c]) Rows[r] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [3:0] e;
      forever begin
         @(negedge Clk);
         if (KeyValid === 1'b1) begin
            last_valid_cycle = cycle_cnt;
            $display("pulse code=%0d held=%0d cycle=%0d", KeyCode, KeyHeld, cycle_cnt);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {28'd0, KeyCode}, 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_code", {28'd0, KeyCode}, {28'd0, e});
               chk("pulse_held", {31'd0, KeyHeld}, 32'd1);
            end
         end
      end
   endtask

   task automatic wait_scans(input int n);
      repeat (n * SCAN) @(negedge Clk);
   endtask

   // Leaves the bench at the negedge just after the wrap into column 0.
   task automatic align_scan();
      int k;
      k = 0;
      while (Cols !== 4'b0111 && k < 40) begin @(negedge Clk); k++; end
      while (Cols !== 4'b1110 && k < 60) begin @(negedge Clk); k++; end
      if (k >= 60) chk("align_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor();
      join_none

      Reset = 1'b1;
      #1;
      chk("rst_cols", {28'd0, Cols}, 32'hE);
      chk("rst_valid", {31'd0, KeyValid}, 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;

      // Asynchronous reset mid-column
      repeat (10) @(negedge Clk);
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      chk("async_cols", {28'd0, Cols}, 32'hE);
      chk("async_code", {28'd0, KeyCode}, 32'd0);
      chk("async_held", {31'd0, KeyHeld}, 32'd0);
      chk("async_valid", {31'd0, KeyValid}, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         logic [3:0] one_hot;
         @(negedge Clk);
         one_hot = 4'b0001 << ((n / 4) % 4);
         chk("cols_step", {28'd0, Cols}, {28'd0, ~one_hot});
      end

      // Single press of key 9
      keys = 16'h0200;
      exp_q.push_back(4'd9);
      wait_scans(6);
      chk("press9_pending", exp_q.size(), 32'd0);
      chk("press9_held", {31'd0, KeyHeld}, 32'd1);
      chk("press9_code", {28'd0, KeyCode}, 32'd9);
      keys = 16'd0;
      repeat (SCAN * 4 + 2) @(negedge Clk);
      chk("release9_held", {31'd0, KeyHeld}, 32'd0);
      wait_scans(1);

      // Bounce on key 9 for two scans, then steady
      align_scan();
      keys = 16'h0200;
      exp_q.push_back(4'd9);
      repeat (6) begin
         repeat (5) @(negedge Clk);
         keys ^= 16'h0200;
      end
      repeat (2) @(negedge Clk);
      mark = cycle_cnt;
      wait_scans(5);
      chk("bounce_pending", exp_q.size(), 32'd0);
      chk("bounce_late_enough", {31'd0, (last_valid_cycle - mark) >= 2 * SCAN}, 32'd1);
      chk("bounce_code", {28'd0, KeyCode}, 32'd9);
      keys = 16'd0;
      wait_scans(5);
      chk("bounce_release", {31'd0, KeyHeld}, 32'd0);

      // Short press of key 5: two aligned scans only
      align_scan();
      keys = 16'h0020;
      wait_scans(2);
      keys = 16'd0;
      wait_scans(5);
      chk("short_code_kept", {28'd0, KeyCode}, 32'd9);
      chk("short_held", {31'd0, KeyHeld}, 32'd0);

      // Multi-key lockout
      keys = 16'h8001;
      wait_scans(6);
      chk("multi_held", {31'd0, KeyHeld}, 32'd0);
      keys = 16'h0001;
      wait_scans(6);
      chk("lock_held", {31'd0, KeyHeld}, 32'd0);
      chk("lock_code", {28'd0, KeyCode}, 32'd9);
      keys = 16'd0;
      wait_scans(5);
      keys = 16'h0008;
      exp_q.push_back(4'd3);
      wait_scans(6);
      chk("key3_pending", exp_q.size(), 32'd0);
      chk("key3_code", {28'd0, KeyCode}, 32'd3);
      chk("key3_held", {31'd0, KeyHeld}, 32'd1);

      // Reset while key 6 is held
      keys = 16'd0;
      wait_scans(5);
      keys = 16'h0040;
      exp_q.push_back(4'd6);
      wait_scans(6);
      chk("key6_pending", exp_q.size(), 32'd0);
      chk("key6_held", {31'd0, KeyHeld}, 32'd1);
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      chk("rst6_held", {31'd0, KeyHeld}, 32'd0);
      chk("rst6_code", {28'd0, KeyCode}, 32'd0);
      chk("rst6_cols", {28'd0, Cols}, 32'hE);
      @(negedge Clk);
      Reset = 1'b0;
      mark = cycle_cnt;
      exp_q.push_back(4'd6);
      repeat ((DEB + 1) * SCAN + 4) @(negedge Clk);
      chk("rst6_repulse", exp_q.size(), 32'd0);
      chk("rst6_latency", {31'd0, (last_valid_cycle - mark) <= (DEB + 1) * SCAN + 1}, 32'd1);
      chk("rst6_code_after", {28'd0, KeyCode}, 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
